// File: rtl/fp16_pkg.sv
// Shared fp16 types and constants for the multiplier sharing logic.
// Tag layout travels alongside the multiplier pipeline, one entry per stage.
package fp16_pkg;

  localparam int FP16_W           = 16;
  localparam int FP16_MUL_LATENCY = 7;
  localparam int TAG_ID_W         = 3;

  typedef logic [FP16_W-1:0] fp16_t;

  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_QNAN = 16'h7E00;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } req_tag_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: combinational grant searching upward from a rotating pointer.
// Zero latency grant; pointer moves past the winner only when advance is strobed.
module rr_arbiter_n #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // Walk offsets from farthest to nearest so the nearest eligible requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (eligible[IDX_W'(cand)]) begin
        grant                  = '0;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one external pipelined fp16 multiplier among NUM_REQ requesters, one accept per cycle.
// Result returns MUL_LATENCY cycles after accept; per-requester in-flight cap gates ready, responses never stall.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MUL_LATENCY     = FP16_MUL_LATENCY,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [FP16_W*NUM_REQ-1:0] req_a,
  input  logic [FP16_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output fp16_t                     rsp_data,
  output fp16_t                     mul_a,
  output fp16_t                     mul_b,
  input  fp16_t                     mul_out,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  req_tag_t           tag_in;
  req_tag_t           tag_out;
  req_tag_t           tag_pipe [MUL_LATENCY];

  rr_arbiter_n #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .eligible  (eligible),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant already implies valid, so any grant is a completed handshake.
  assign accept    = |grant;
  assign req_ready = grant;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_a = req_a[FP16_W*i +: FP16_W];
        mul_b = req_b[FP16_W*i +: FP16_W];
      end
    end
  end

  assign tag_in  = '{valid: accept, id: TAG_ID_W'(grant_idx)};
  assign tag_out = tag_pipe[MUL_LATENCY-1];

  // The multiplier has no valid of its own; this shift register is the only record of what is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < MUL_LATENCY; s++) begin
      busy = busy | tag_pipe[s].valid;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
    end
  end

  assign rsp_data = mul_out;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    assign inc = grant[i];
    assign dec = rsp_valid[i];

    // Registered count: a response this cycle only frees a slot from the next cycle on.
    assign eligible[i] = req_valid[i] && (cnt < CNT_MAX) && enable && !rst;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else begin
        assert (!(dec && !inc && cnt == '0));
        assert (!(inc && !dec && cnt == CNT_MAX));
        if (inc && !dec) begin
          cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Bench for fp16_mul_arbiter: directed scenarios plus random traffic against a queue-based model.
// A behavioural 7-stage multiplier sits on mul_a/mul_b/mul_out.
module tb_fp16_mul_arbiter;
  import fp16_pkg::*;

  localparam int N    = 4;
  localparam int LAT  = 7;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]  rsp_valid;
  fp16_t         rsp_data;
  fp16_t         mul_a;
  fp16_t         mul_b;
  fp16_t         mul_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fp16_mul_arbiter #(
    .NUM_REQ         (N),
    .MUL_LATENCY     (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact for the operand set used here (short mantissas); truncates otherwise.
  function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
    logic        s;
    int          e;
    logic [21:0] m;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 0);
    a_zero = (a[14:10] == 5'h00);
    b_zero = (b[14:10] == 5'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP16_QNAN;
    if (a_inf || b_inf) return {s, 5'h1f, 10'h000};
    if (a_zero || b_zero) return {s, 15'h0000};
    m = {11'h000, 1'b1, a[9:0]} * {11'h000, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (m[21]) begin
      e = e + 1;
      m = m >> 1;
    end
    if (e >= 31) return {s, 5'h1f, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    return {s, e[4:0], m[19:10]};
  endfunction

  fp16_t mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= fp16_mul(mul_a, mul_b);
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_out = mpipe[LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    fp16_t data;
    int    due;
  } exp_t;

  exp_t         q [N][$];
  int           mptr = 0;
  logic [N-1:0] acc_last = '0;

  // Reference: in-flight count per requester is the length of its pending-result queue.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    fp16_t        ea, eb;
    int           tot, c;
    bit           due;
    exp_t         e;
    exp_rdy  = '0;
    ea       = '0;
    eb       = '0;
    tot      = 0;
    acc_last = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) q[i].delete();
      mptr = 0;
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mul_a", mul_a, 0);
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (exp_rdy == '0 && req_valid[c] && q[c].size() < MAXO && enable) exp_rdy[c] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        tot = tot + q[i].size();
        if (exp_rdy[i]) begin
          ea = req_a[16*i +: 16];
          eb = req_b[16*i +: 16];
        end
      end
      check_eq("ready", req_ready, exp_rdy);
      check_eq("mul_a", mul_a, ea);
      check_eq("mul_b", mul_b, eb);
      check_eq("busy", busy, tot > 0);
      for (int i = 0; i < N; i++) begin
        due = (q[i].size() > 0) && (q[i][0].due == cyc);
        check_eq("rsp_valid", rsp_valid[i], due);
        if (due) begin
          check_eq("rsp_data", rsp_data, q[i][0].data);
          void'(q[i].pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (exp_rdy[i]) begin
          e.data = fp16_mul(req_a[16*i +: 16], req_b[16*i +: 16]);
          e.due  = cyc + LAT;
          q[i].push_back(e);
          mptr        = (i + 1) % N;
          acc_last[i] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Issues one op on an idle pipeline and checks timing and data; enters and leaves at posedge+1.
  task automatic single_op(input int idx, input fp16_t a, input fp16_t b, input fp16_t exp, input string tag);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    samp();
    check_eq({tag, "_rdy"}, req_ready, 1 << idx);
    check_eq({tag, "_busy0"}, busy, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      samp();
      check_eq({tag, "_busy"}, busy, k <= 7);
      check_eq({tag, "_rsp"}, rsp_valid, (k == 7) ? (1 << idx) : 0);
      if (k == 7) check_eq({tag, "_dat"}, rsp_data, exp);
    end
    tick();
  endtask

  fp16_t ops [10] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3E00, 16'h3800,
                      16'h4400, 16'hBC00, 16'h7C00, 16'h0000, 16'h7E00};

  initial begin
    logic [11:0] pat;
    int          nrsp;
    logic        rdy_seen;

    rst       = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    #2;
    check_eq("reset_ready", req_ready, 0);
    check_eq("reset_rsp", rsp_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_mul_a", mul_a, 0);
    check_eq("reset_mul_b", mul_b, 0);
    tick();
    tick();
    rst    = 1'b0;
    enable = 1'b1;

    // All four requesting continuously from a fresh pointer.
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'h3E00;
      req_b[16*i +: 16] = 16'h3E00;
    end
    req_valid = '1;
    nrsp = 0;
    for (int k = 0; k < 8; k++) begin
      samp();
      check_eq("rr_grant", req_ready, 32'd1 << (k % 4));
      if (|rsp_valid) begin
        nrsp++;
        check_eq("rr_data", rsp_data, 16'h4080);
      end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 12; k++) begin
      samp();
      if (|rsp_valid) begin
        nrsp++;
        check_eq("rr_data", rsp_data, 16'h4080);
      end
      tick();
    end
    check_eq("rr_rsp_count", nrsp, 8);

    single_op(0, FP16_ONE, 16'h4000, 16'h4000, "single");

    // One requester hitting its in-flight cap.
    req_a[31:16] = FP16_ONE;
    req_b[31:16] = FP16_ONE;
    req_valid    = 4'b0010;
    pat          = '0;
    for (int k = 0; k < 12; k++) begin
      samp();
      pat[11-k] = req_ready[1];
      tick();
    end
    check_eq("throttle_pattern", pat, 12'b1111_0000_1111);
    req_valid = '0;
    repeat (12) tick();

    // enable dropped after three accepts.
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'h3E00;
      req_b[16*i +: 16] = 16'h3E00;
    end
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      samp();
      check_eq("en_accept", $countones(req_ready), 1);
      tick();
    end
    enable   = 1'b0;
    nrsp     = 0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      samp();
      rdy_seen = rdy_seen | (|req_ready);
      nrsp     = nrsp + $countones(rsp_valid);
      if (k == 6) check_eq("en_busy_last", busy, 1);
      if (k == 7) check_eq("en_busy_fall", busy, 0);
      tick();
    end
    check_eq("en_no_ready", rdy_seen, 0);
    check_eq("en_rsp_count", nrsp, 3);
    req_valid = '0;
    enable    = 1'b1;
    tick();

    // Asynchronous reset with five ops in flight.
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      samp();
      check_eq("rst_fill_accept", $countones(req_ready), 1);
      tick();
    end
    req_valid = '0;
    #1;
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_rsp", rsp_valid, 0);
    check_eq("async_rst_ready", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 10; k++) begin
      samp();
      nrsp = nrsp + $countones(rsp_valid);
      tick();
    end
    check_eq("post_rst_no_rsp", nrsp, 0);
    single_op(2, 16'h4200, 16'h4000, 16'h4600, "post_rst");

    single_op(3, 16'h7C00, 16'h0000, FP16_QNAN, "nan");

    // Random traffic; the monitor checks every cycle against the queue model.
    for (int n = 0; n < 3000; n++) begin
      if (enable && $urandom_range(0, 99) < 3) enable = 1'b0;
      else if (!enable && $urandom_range(0, 99) < 20) enable = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc_last[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 6) begin
          req_valid[i]      = 1'b1;
          req_a[16*i +: 16] = ops[$urandom_range(0, 9)];
          req_b[16*i +: 16] = ops[$urandom_range(0, 9)];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      samp();
      tick();
    end
    req_valid = '0;
    enable    = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < N; i++) check_eq("final_drained", q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
